ofm_accum_buffer: RTL

Multi-channel output-feature-map buffer for the transposed-convolution datapath. It sits between the PE array and the write-back path. Scattered partial products from overlapping kernel windows are summed in place with read-modify-write, then the finished map is drained in raster order under a valid/ready handshake. It generalises the single-channel FIFO-style output buffer with per-channel addressing, in-place accumulation, a clear phase and backpressure.

---
 rtl/ofm_accum_buffer_if.sv | 34 +++
 rtl/ofm_accum_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ofm_accum_buffer_if.sv
// rtl/ofm_accum_buffer_if.sv - accumulate request and drain stream bundle for ofm_accum_buffer
// Purpose: groups the accumulate request channel and the drain valid/ready stream.
// Signals:
//   acc_en/acc_ch/acc_addr/acc_data : accumulate request (master -> slave)
//   acc_ready                       : slave is in its accumulate phase
//   d_out/d_valid/d_ch/d_last       : drained word stream (slave -> master)
//   d_ready                         : consumer ready (master -> slave)
// Modports: master (producer/consumer side), slave (buffer side).
interface ofm_accum_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 8,
    parameter int CW         = 2
);
    logic                  acc_en;
    logic [CW-1:0]         acc_ch;
    logic [AW-1:0]         acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  acc_ready;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  d_valid;
    logic [CW-1:0]         d_ch;
    logic                  d_last;
    logic                  d_ready;

    modport master (
        output acc_en, acc_ch, acc_addr, acc_data, d_ready,
        input  acc_ready, d_out, d_valid, d_ch, d_last
    );

    modport slave (
        input  acc_en, acc_ch, acc_addr, acc_data, d_ready,
        output acc_ready, d_out, d_valid, d_ch, d_last
    );
endinterface

// File: rtl/ofm_accum_buffer.sv
// rtl/ofm_accum_buffer.sv - multi-channel output feature map accumulate buffer with raster drain
// Purpose: zeroes, accumulates scattered partial products in place (read-modify-write with
//   forwarding) and drains all channels in raster order through a 2-entry output skid.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : start zeroing every entry (IDLE only, wins over drain_start)
//   acc_done     : leave the accumulate phase
//   drain_start  : start the sequential read-out (IDLE only)
//   busy         : state is not IDLE
//   bus (slave)  : accumulate request channel and drain stream
// Build option: define ACC_SATURATE_EN to saturate sums to the signed bounds instead of wrapping.
module ofm_accum_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int IFM_SIZE    = 9,
    parameter int KERNEL_SIZE = 4,
    parameter int STRIDE      = 2,
    parameter int PAD         = 2,
    parameter int CHANNELS    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                acc_done,
    input  logic                drain_start,
    output logic                busy,
    ofm_accum_buffer_if.slave   bus
);
    localparam int OFM   = (IFM_SIZE - 1) * STRIDE - 2 * PAD + KERNEL_SIZE;
    localparam int DEPTH = OFM * OFM;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TOTAL = CHANNELS * DEPTH;
    localparam int MW    = $clog2(TOTAL);
    localparam int DW    = DATA_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_FLUSH, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_mem [TOTAL];
    logic [MW-1:0]   r_clr_idx;
    logic            r_flush;

    // Accumulate pipeline: p1 holds the accepted request, p2 the sum being written.
    logic            r_p1_valid, r_p2_valid;
    logic [MW-1:0]   r_p1_idx, r_p2_idx;
    logic [DW-1:0]   r_p1_data, r_p2_sum;
    logic [DW-1:0]   w_old, w_sum;
    logic            w_acc_take, w_acc_fire, w_acc_inrange;
    logic [MW-1:0]   w_acc_idx;

    // Drain: read pointer, one read stage, then a 2-entry output FIFO.
    logic [CW-1:0]   r_drn_ch;
    logic [AW-1:0]   r_drn_addr;
    logic            r_drn_issued;
    logic            r_rs_valid, r_rs_last;
    logic [DW-1:0]   r_rs_data;
    logic [CW-1:0]   r_rs_ch;
    logic [DW-1:0]   r_fq_data [2];
    logic [CW-1:0]   r_fq_ch   [2];
    logic            r_fq_last [2];
    logic            r_fq_wp, r_fq_rp;
    logic [1:0]      r_fq_cnt;
    logic            w_pop, w_issue, w_drn_last_pos;
    logic [MW-1:0]   w_drn_idx;

    // Bounds are checked before flattening so an oversize address cannot land in another channel.
    assign w_acc_inrange = (int'(bus.acc_addr) < DEPTH) && (int'(bus.acc_ch) < CHANNELS);
    assign w_acc_idx     = MW'(int'(bus.acc_ch) * DEPTH + int'(bus.acc_addr));
    assign w_acc_take    = bus.acc_en && ((r_state == S_ACCUM) ||
                           ((r_state == S_IDLE) && !clear && !drain_start));
    assign w_acc_fire    = w_acc_take && w_acc_inrange;

    assign w_pop          = (r_fq_cnt != 2'd0) && bus.d_ready;
    assign w_drn_idx      = MW'(int'(r_drn_ch) * DEPTH + int'(r_drn_addr));
    assign w_drn_last_pos = (int'(r_drn_ch) == CHANNELS - 1) && (int'(r_drn_addr) == DEPTH - 1);
    // Issue only while FIFO plus in-flight read stay within two entries after this cycle's pop.
    assign w_issue        = (r_state == S_DRAIN) && !r_drn_issued &&
                            ((int'(r_fq_cnt) + int'(r_rs_valid)) < (2 + int'(w_pop)));

    assign bus.d_valid   = (r_fq_cnt != 2'd0);
    assign bus.d_out     = r_fq_data[r_fq_rp];
    assign bus.d_ch      = r_fq_ch[r_fq_rp];
    assign bus.d_last    = r_fq_last[r_fq_rp];
    assign bus.acc_ready = (r_state == S_ACCUM);
    assign busy          = (r_state != S_IDLE);

    always_comb begin
        w_old = r_mem[r_p1_idx];
        if (r_p2_valid && (r_p2_idx == r_p1_idx)) begin
            w_old = r_p2_sum;
        end
`ifdef ACC_SATURATE_EN
        begin
            logic [DW:0] w_wide;
            w_wide = {w_old[DW-1], w_old} + {r_p1_data[DW-1], r_p1_data};
            if (w_wide[DW] != w_wide[DW-1]) begin
                w_sum = w_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end else begin
                w_sum = w_wide[DW-1:0];
            end
        end
`else
        w_sum = w_old + r_p1_data;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear)            w_state_nxt = S_CLEAR;
                else if (drain_start) w_state_nxt = S_DRAIN;
                else if (bus.acc_en)  w_state_nxt = S_ACCUM;
            end
            S_CLEAR: if (r_clr_idx == MW'(TOTAL - 1)) w_state_nxt = S_IDLE;
            S_ACCUM: if (acc_done) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_flush) w_state_nxt = S_IDLE;
            S_DRAIN: if (w_pop && r_fq_last[r_fq_rp]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_clr_idx    <= '0;
            r_flush      <= 1'b0;
            r_p1_valid   <= 1'b0;
            r_p1_idx     <= '0;
            r_p1_data    <= '0;
            r_p2_valid   <= 1'b0;
            r_p2_idx     <= '0;
            r_p2_sum     <= '0;
            r_drn_ch     <= '0;
            r_drn_addr   <= '0;
            r_drn_issued <= 1'b0;
            r_rs_valid   <= 1'b0;
            r_rs_data    <= '0;
            r_rs_ch      <= '0;
            r_rs_last    <= 1'b0;
            r_fq_data    <= '{default: '0};
            r_fq_ch      <= '{default: '0};
            r_fq_last    <= '{default: 1'b0};
            r_fq_wp      <= 1'b0;
            r_fq_rp      <= 1'b0;
            r_fq_cnt     <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= (r_state == S_CLEAR) ? r_clr_idx + MW'(1) : '0;
            r_flush   <= (r_state == S_FLUSH) ? !r_flush : 1'b0;

            r_p1_valid <= w_acc_fire;
            if (w_acc_fire) begin
                r_p1_idx  <= w_acc_idx;
                r_p1_data <= bus.acc_data;
            end
            r_p2_valid <= r_p1_valid;
            if (r_p1_valid) begin
                r_p2_idx <= r_p1_idx;
                r_p2_sum <= w_sum;
            end

            if (r_state != S_DRAIN) begin
                r_drn_ch     <= '0;
                r_drn_addr   <= '0;
                r_drn_issued <= 1'b0;
            end else if (w_issue) begin
                if (w_drn_last_pos) begin
                    r_drn_issued <= 1'b1;
                end else if (int'(r_drn_addr) == DEPTH - 1) begin
                    r_drn_addr <= '0;
                    r_drn_ch   <= r_drn_ch + CW'(1);
                end else begin
                    r_drn_addr <= r_drn_addr + AW'(1);
                end
            end
            r_rs_valid <= w_issue;
            if (w_issue) begin
                r_rs_data <= r_mem[w_drn_idx];
                r_rs_ch   <= r_drn_ch;
                r_rs_last <= w_drn_last_pos;
            end

            if (r_rs_valid) begin
                r_fq_data[r_fq_wp] <= r_rs_data;
                r_fq_ch[r_fq_wp]   <= r_rs_ch;
                r_fq_last[r_fq_wp] <= r_rs_last;
                r_fq_wp            <= !r_fq_wp;
            end
            if (w_pop) begin
                r_fq_rp <= !r_fq_rp;
            end
            r_fq_cnt <= r_fq_cnt + 2'(r_rs_valid) - 2'(w_pop);
        end
    end

    // Storage has no reset; contents are only meaningful after a clear.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else if (r_p2_valid) begin
            r_mem[r_p2_idx] <= r_p2_sum;
        end
    end
endmodule
